// File: rtl/priv_pkg.sv
// Shared types and register indices for the privileged register file and trap controller.
package priv_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam int RM_EPC    = 0;
    localparam int RM_FADDR  = 1;
    localparam int RM_INFO   = 2;
    localparam int RM_CAUSE  = 3;
    localparam int RM_STATUS = 4;

endpackage

// File: rtl/priv_trap_stack.sv
// LIFO of saved trap contexts; the element type is supplied by the instantiating module.
module priv_trap_stack #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  T                 push_data,
    output T                 top,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign depth  = count;
    assign wr_ptr = PTR_W'(count);
    assign rd_ptr = PTR_W'(count - CNT_W'(1));
    assign top    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/priv_trap_ctrl.sv
// Privileged rm register file with nested traps, iret, double-fault halt and a read port.
// Define PRIV_TRAP_COUNT_EN to add per-cause saturating trap counters readable at idx NUM_RM+cause.
module priv_trap_ctrl
    import priv_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter int              NUM_RM        = 5,
    parameter int              CAUSE_W       = 3,
    parameter int              NEST_DEPTH    = 2,
    parameter logic [XLEN-1:0] TRAP_VECTOR   = 'h2000,
    parameter logic [XLEN-1:0] DFAULT_VECTOR = 'h3000,
    parameter logic [XLEN-1:0] RM0_RESET     = 'h1000,
    localparam int             IDX_W         = $clog2(NUM_RM + 2**CAUSE_W),
    localparam int             DEPTH_W       = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IDX_W-1:0]   in_rm_idx,
    input  logic               in_write_enable,
    input  logic [XLEN-1:0]    in_write_data,
    input  logic [CAUSE_W-1:0] in_exception_vector,
    input  logic [XLEN-1:0]    in_fault_pc,
    input  logic [XLEN-1:0]    in_fault_addr,
    input  logic [XLEN-1:0]    in_additional_info,
    output logic [XLEN-1:0]    out_rd_data,
    output logic               out_supervisor_mode,
    output logic               out_overwrite_PC,
    output logic [XLEN-1:0]    out_new_address,
    output logic               out_priv_violation,
    output logic [DEPTH_W-1:0] out_nest_depth,
    output logic               out_halted
);
    typedef struct packed {
        logic [XLEN-1:0] epc;
        logic [XLEN-1:0] faddr;
        logic [XLEN-1:0] info;
        logic [XLEN-1:0] cause;
        logic            sup;
    } ctx_t;

    state_t          state, state_next;
    logic            halt_pending;
    logic [XLEN-1:0] rm [NUM_RM];
    logic [XLEN-1:0] target;
    logic            viol_q;

    logic active, trap, wr, sup, is_status, in_range;
    logic iret, rm_wr, viol;
    logic stk_push, stk_pop, stk_full, stk_empty;
    ctx_t push_ctx, pop_ctx;

    // Once the double-fault redirect is scheduled, nothing else is accepted.
    assign active    = (state != ST_HALT) && !halt_pending;
    assign trap      = active && (in_exception_vector != '0);
    assign wr        = active && !trap && in_write_enable;
    assign sup       = rm[RM_STATUS][0];
    assign is_status = (in_rm_idx == IDX_W'(RM_STATUS));
    assign in_range  = (in_rm_idx < IDX_W'(NUM_RM));
    assign iret      = wr && sup && is_status;
    assign rm_wr     = wr && sup && in_range && !is_status;
    assign viol      = wr && !sup;
    assign stk_push  = trap && !stk_full;
    assign stk_pop   = iret && !stk_empty;

    assign push_ctx = '{epc:   rm[RM_EPC],
                        faddr: rm[RM_FADDR],
                        info:  rm[RM_INFO],
                        cause: rm[RM_CAUSE],
                        sup:   sup};

    priv_trap_stack #(
        .DEPTH (NEST_DEPTH),
        .T     (ctx_t)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (push_ctx),
        .top       (pop_ctx),
        .depth     (out_nest_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN, ST_REDIRECT: begin
                if (trap || iret) begin
                    state_next = ST_REDIRECT;
                end else if (halt_pending) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_RM; i++) begin
                rm[i] <= '0;
            end
            rm[RM_EPC]    <= RM0_RESET;
            rm[RM_STATUS] <= XLEN'(1);
            target        <= '0;
            halt_pending  <= 1'b0;
            viol_q        <= 1'b0;
        end else begin
            viol_q <= viol;
            if (trap) begin
                halt_pending        <= stk_full;
                target              <= stk_full ? DFAULT_VECTOR : TRAP_VECTOR;
                rm[RM_EPC]          <= in_fault_pc;
                rm[RM_FADDR]        <= in_fault_addr;
                rm[RM_INFO]         <= in_additional_info;
                rm[RM_CAUSE]        <= XLEN'(in_exception_vector);
                rm[RM_STATUS][0]    <= 1'b1;
            end else if (iret) begin
                target <= rm[RM_EPC];
                if (!stk_empty) begin
                    rm[RM_EPC]       <= pop_ctx.epc;
                    rm[RM_FADDR]     <= pop_ctx.faddr;
                    rm[RM_INFO]      <= pop_ctx.info;
                    rm[RM_CAUSE]     <= pop_ctx.cause;
                    rm[RM_STATUS][0] <= pop_ctx.sup;
                end else begin
                    rm[RM_STATUS] <= in_write_data;
                end
            end else if (rm_wr) begin
                for (int i = 0; i < NUM_RM; i++) begin
                    if (in_rm_idx == IDX_W'(i)) begin
                        rm[i] <= in_write_data;
                    end
                end
            end
        end
    end

`ifdef PRIV_TRAP_COUNT_EN
    localparam int NUM_CAUSE = 2**CAUSE_W;

    logic [15:0] trap_count [1:NUM_CAUSE-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 1; c < NUM_CAUSE; c++) begin
                trap_count[c] <= '0;
            end
        end else if (trap) begin
            for (int c = 1; c < NUM_CAUSE; c++) begin
                if (in_exception_vector == CAUSE_W'(c) && trap_count[c] != '1) begin
                    trap_count[c] <= trap_count[c] + 16'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        out_rd_data = '0;
        for (int i = 0; i < NUM_RM; i++) begin
            if (in_rm_idx == IDX_W'(i)) begin
                out_rd_data = rm[i];
            end
        end
`ifdef PRIV_TRAP_COUNT_EN
        for (int c = 1; c < NUM_CAUSE; c++) begin
            if (in_rm_idx == IDX_W'(NUM_RM + c)) begin
                out_rd_data = XLEN'(trap_count[c]);
            end
        end
`endif
    end

    assign out_supervisor_mode = sup;
    assign out_overwrite_PC    = (state == ST_REDIRECT);
    assign out_new_address     = (state == ST_REDIRECT) ? target : '0;
    assign out_priv_violation  = viol_q;
    assign out_halted          = (state == ST_HALT);

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Self-checking bench for priv_trap_ctrl: redirect targets go through a scoreboard queue.
module tb_priv_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_rm_idx;
    logic        in_write_enable;
    logic [31:0] in_write_data;
    logic [2:0]  in_exception_vector;
    logic [31:0] in_fault_pc;
    logic [31:0] in_fault_addr;
    logic [31:0] in_additional_info;
    logic [31:0] out_rd_data;
    logic        out_supervisor_mode;
    logic        out_overwrite_PC;
    logic [31:0] out_new_address;
    logic        out_priv_violation;
    logic [1:0]  out_nest_depth;
    logic        out_halted;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];

    priv_trap_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .in_rm_idx           (in_rm_idx),
        .in_write_enable     (in_write_enable),
        .in_write_data       (in_write_data),
        .in_exception_vector (in_exception_vector),
        .in_fault_pc         (in_fault_pc),
        .in_fault_addr       (in_fault_addr),
        .in_additional_info  (in_additional_info),
        .out_rd_data         (out_rd_data),
        .out_supervisor_mode (out_supervisor_mode),
        .out_overwrite_PC    (out_overwrite_PC),
        .out_new_address     (out_new_address),
        .out_priv_violation  (out_priv_violation),
        .out_nest_depth      (out_nest_depth),
        .out_halted          (out_halted)
    );

    always #5 clk = ~clk;

    task automatic idle();
        in_rm_idx           = '0;
        in_write_enable     = 1'b0;
        in_write_data       = '0;
        in_exception_vector = '0;
        in_fault_pc         = '0;
        in_fault_addr       = '0;
        in_additional_info  = '0;
    endtask

    task automatic drive_trap(input logic [2:0] cause, input logic [31:0] pc, input logic [31:0] addr,
                              input logic [31:0] info);
        in_exception_vector = cause;
        in_fault_pc         = pc;
        in_fault_addr       = addr;
        in_additional_info  = info;
    endtask

    task automatic drive_write(input logic [3:0] idx, input logic [31:0] data);
        in_rm_idx       = idx;
        in_write_enable = 1'b1;
        in_write_data   = data;
    endtask

    // One clock: apply inputs at the edge, sample at the following falling edge, score redirects.
    task automatic cycle();
        logic [31:0] exp_addr;
        logic        exp_pulse;
        @(posedge clk);
        @(negedge clk);
        exp_pulse = (exp_q.size() != 0);
        exp_addr  = exp_pulse ? exp_q.pop_front() : 32'h0;
        n_checks++;
        if (out_overwrite_PC !== exp_pulse) begin
            n_fail++;
            $display("FAIL redirect_pulse @%0t: got %b want %b", $time, out_overwrite_PC, exp_pulse);
        end
        n_checks++;
        if (out_new_address !== exp_addr) begin
            n_fail++;
            $display("FAIL redirect_target @%0t: got %h want %h", $time, out_new_address, exp_addr);
        end
        idle();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle();
        repeat (2) cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        in_rm_idx = 4'd0; #1;
        n_checks++; if (out_rd_data !== 32'h1000) begin n_fail++; $display("FAIL reset_rm0: got %h want %h", out_rd_data, 32'h1000); end
        in_rm_idx = 4'd4; #1;
        n_checks++; if (out_rd_data !== 32'h1) begin n_fail++; $display("FAIL reset_rm4: got %h want %h", out_rd_data, 32'h1); end
        n_checks++; if (out_supervisor_mode !== 1'b1) begin n_fail++; $display("FAIL reset_sup: got %b want 1", out_supervisor_mode); end
        n_checks++; if (out_nest_depth !== 2'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", out_nest_depth); end
        n_checks++; if (out_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", out_halted); end
        n_checks++; if (out_priv_violation !== 1'b0) begin n_fail++; $display("FAIL reset_viol: got %b want 0", out_priv_violation); end
        in_rm_idx = 4'd0;
    endtask

    task automatic test_rm_write();
        drive_write(4'd2, 32'hBEEF); cycle();
        drive_write(4'd0, 32'h1234); cycle();
        n_checks++; if (out_priv_violation !== 1'b0) begin n_fail++; $display("FAIL wr_viol: got %b want 0", out_priv_violation); end
        in_rm_idx = 4'd2; #1;
        n_checks++; if (out_rd_data !== 32'hBEEF) begin n_fail++; $display("FAIL wr_rm2: got %h want %h", out_rd_data, 32'hBEEF); end
        in_rm_idx = 4'd0; #1;
        n_checks++; if (out_rd_data !== 32'h1234) begin n_fail++; $display("FAIL wr_rm0: got %h want %h", out_rd_data, 32'h1234); end
    endtask

    task automatic test_trap();
        drive_trap(3'd3, 32'h40, 32'h80, 32'h55); exp_q.push_back(32'h2000); cycle();
        in_rm_idx = 4'd0; #1;
        n_checks++; if (out_rd_data !== 32'h40) begin n_fail++; $display("FAIL trap_rm0: got %h want %h", out_rd_data, 32'h40); end
        in_rm_idx = 4'd1; #1;
        n_checks++; if (out_rd_data !== 32'h80) begin n_fail++; $display("FAIL trap_rm1: got %h want %h", out_rd_data, 32'h80); end
        in_rm_idx = 4'd2; #1;
        n_checks++; if (out_rd_data !== 32'h55) begin n_fail++; $display("FAIL trap_rm2: got %h want %h", out_rd_data, 32'h55); end
        in_rm_idx = 4'd3; #1;
        n_checks++; if (out_rd_data !== 32'h3) begin n_fail++; $display("FAIL trap_rm3: got %h want %h", out_rd_data, 32'h3); end
        n_checks++; if (out_nest_depth !== 2'd1) begin n_fail++; $display("FAIL trap_depth: got %0d want 1", out_nest_depth); end
        cycle();
        drive_write(4'd4, 32'h0); exp_q.push_back(32'h40); cycle();
        in_rm_idx = 4'd0; #1;
        n_checks++; if (out_rd_data !== 32'h1234) begin n_fail++; $display("FAIL iret_rm0: got %h want %h", out_rd_data, 32'h1234); end
        n_checks++; if (out_nest_depth !== 2'd0) begin n_fail++; $display("FAIL iret_depth: got %0d want 0", out_nest_depth); end
        n_checks++; if (out_supervisor_mode !== 1'b1) begin n_fail++; $display("FAIL iret_sup: got %b want 1", out_supervisor_mode); end
        cycle();
    endtask

    task automatic test_back_to_back_nested();
        drive_trap(3'd1, 32'h40, 32'h0, 32'h0); exp_q.push_back(32'h2000); cycle();
        drive_trap(3'd2, 32'h2004, 32'h0, 32'h0); exp_q.push_back(32'h2000); cycle();
        n_checks++; if (out_nest_depth !== 2'd2) begin n_fail++; $display("FAIL nest_depth2: got %0d want 2", out_nest_depth); end
        drive_write(4'd4, 32'h0); exp_q.push_back(32'h2004); cycle();
        in_rm_idx = 4'd0; #1;
        n_checks++; if (out_rd_data !== 32'h40) begin n_fail++; $display("FAIL nest_rm0: got %h want %h", out_rd_data, 32'h40); end
        n_checks++; if (out_nest_depth !== 2'd1) begin n_fail++; $display("FAIL nest_depth1: got %0d want 1", out_nest_depth); end
        drive_write(4'd4, 32'h0); exp_q.push_back(32'h40); cycle();
        in_rm_idx = 4'd0; #1;
        n_checks++; if (out_rd_data !== 32'h1234) begin n_fail++; $display("FAIL nest_rm0_final: got %h want %h", out_rd_data, 32'h1234); end
        cycle();
    endtask

    task automatic test_trap_write_same_cycle();
        apply_reset();
        drive_trap(3'd1, 32'h90, 32'hA0, 32'h77); drive_write(4'd2, 32'hDEAD); exp_q.push_back(32'h2000); cycle();
        n_checks++; if (out_priv_violation !== 1'b0) begin n_fail++; $display("FAIL same_viol: got %b want 0", out_priv_violation); end
        in_rm_idx = 4'd2; #1;
        n_checks++; if (out_rd_data !== 32'h77) begin n_fail++; $display("FAIL same_rm2: got %h want %h", out_rd_data, 32'h77); end
        in_rm_idx = 4'd6; #1;
`ifdef PRIV_TRAP_COUNT_EN
        n_checks++; if (out_rd_data !== 32'h1) begin n_fail++; $display("FAIL same_count1: got %h want %h", out_rd_data, 32'h1); end
`else
        n_checks++; if (out_rd_data !== 32'h0) begin n_fail++; $display("FAIL same_count1: got %h want %h", out_rd_data, 32'h0); end
`endif
        drive_write(4'd4, 32'h0); exp_q.push_back(32'h90); cycle();
        cycle();
    endtask

    task automatic test_out_of_range();
        drive_write(4'd14, 32'hFFFF); cycle();
        n_checks++; if (out_priv_violation !== 1'b0) begin n_fail++; $display("FAIL oor_viol: got %b want 0", out_priv_violation); end
        in_rm_idx = 4'd14; #1;
        n_checks++; if (out_rd_data !== 32'h0) begin n_fail++; $display("FAIL oor_read: got %h want 0", out_rd_data); end
        in_rm_idx = 4'd0; #1;
        n_checks++; if (out_rd_data !== 32'h1000) begin n_fail++; $display("FAIL oor_rm0: got %h want %h", out_rd_data, 32'h1000); end
    endtask

    task automatic test_user_mode();
        apply_reset();
        drive_write(4'd4, 32'h0); exp_q.push_back(32'h1000); cycle();
        n_checks++; if (out_supervisor_mode !== 1'b0) begin n_fail++; $display("FAIL user_sup: got %b want 0", out_supervisor_mode); end
        drive_write(4'd1, 32'h1234); cycle();
        n_checks++; if (out_priv_violation !== 1'b1) begin n_fail++; $display("FAIL user_viol: got %b want 1", out_priv_violation); end
        cycle();
        n_checks++; if (out_priv_violation !== 1'b0) begin n_fail++; $display("FAIL user_viol_end: got %b want 0", out_priv_violation); end
        in_rm_idx = 4'd1; #1;
        n_checks++; if (out_rd_data !== 32'h0) begin n_fail++; $display("FAIL user_rm1: got %h want 0", out_rd_data); end
        drive_trap(3'd2, 32'h60, 32'h0, 32'h0); exp_q.push_back(32'h2000); cycle();
        n_checks++; if (out_supervisor_mode !== 1'b1) begin n_fail++; $display("FAIL user_trap_sup: got %b want 1", out_supervisor_mode); end
        drive_write(4'd4, 32'hFF); exp_q.push_back(32'h60); cycle();
        n_checks++; if (out_supervisor_mode !== 1'b0) begin n_fail++; $display("FAIL user_iret_sup: got %b want 0", out_supervisor_mode); end
        n_checks++; if (out_nest_depth !== 2'd0) begin n_fail++; $display("FAIL user_iret_depth: got %0d want 0", out_nest_depth); end
        cycle();
    endtask

    task automatic test_double_fault();
        apply_reset();
        drive_trap(3'd1, 32'h40, 32'h0, 32'h0); exp_q.push_back(32'h2000); cycle();
        drive_trap(3'd2, 32'h2004, 32'h0, 32'h0); exp_q.push_back(32'h2000); cycle();
        drive_trap(3'd5, 32'h2008, 32'h0, 32'h0); exp_q.push_back(32'h3000); cycle();
        n_checks++; if (out_nest_depth !== 2'd2) begin n_fail++; $display("FAIL df_depth: got %0d want 2", out_nest_depth); end
        cycle();
        n_checks++; if (out_halted !== 1'b1) begin n_fail++; $display("FAIL df_halted: got %b want 1", out_halted); end
        drive_trap(3'd4, 32'h5000, 32'h0, 32'h0); cycle();
        drive_write(4'd4, 32'h0); cycle();
        drive_write(4'd0, 32'hABCD); cycle();
        n_checks++; if (out_halted !== 1'b1) begin n_fail++; $display("FAIL df_halted_hold: got %b want 1", out_halted); end
        in_rm_idx = 4'd0; #1;
        n_checks++; if (out_rd_data !== 32'h2008) begin n_fail++; $display("FAIL df_rm0: got %h want %h", out_rd_data, 32'h2008); end
        in_rm_idx = 4'd3; #1;
        n_checks++; if (out_rd_data !== 32'h5) begin n_fail++; $display("FAIL df_rm3: got %h want %h", out_rd_data, 32'h5); end
        in_rm_idx = 4'd10; #1;
`ifdef PRIV_TRAP_COUNT_EN
        n_checks++; if (out_rd_data !== 32'h1) begin n_fail++; $display("FAIL df_count5: got %h want %h", out_rd_data, 32'h1); end
`else
        n_checks++; if (out_rd_data !== 32'h0) begin n_fail++; $display("FAIL df_count5: got %h want %h", out_rd_data, 32'h0); end
`endif
        apply_reset();
        n_checks++; if (out_halted !== 1'b0) begin n_fail++; $display("FAIL df_reset_halted: got %b want 0", out_halted); end
        n_checks++; if (out_nest_depth !== 2'd0) begin n_fail++; $display("FAIL df_reset_depth: got %0d want 0", out_nest_depth); end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_rm_write();
        test_trap();
        test_back_to_back_nested();
        test_trap_write_same_cycle();
        test_out_of_range();
        test_user_mode();
        test_double_fault();
        cycle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
